// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer line writer.
// Geometry constants reflect the default 640x480 sensor mode.
package fb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } fb_state_e;

    localparam int WIDTH_DEF      = 640;
    localparam int HEIGHT_DEF     = 480;
    localparam int WORDS_PER_LINE = WIDTH_DEF / 4;
    localparam int FB_WORDS       = WIDTH_DEF * HEIGHT_DEF / 4;

    // Bit positions inside err_flags = {sync, short_frame, long_frame, line_len}
    localparam int ERR_LINE_LEN    = 0;
    localparam int ERR_LONG_FRAME  = 1;
    localparam int ERR_SHORT_FRAME = 2;
    localparam int ERR_SYNC        = 3;

    function automatic int words_per_line(input int width);
        return width / 4;
    endfunction

endpackage

// File: rtl/fb_line_writer_if.sv
// Pixel-side inputs and RAM-side outputs of the line writer, bundled.
// The slave modport is the writer's view; master is the driver/observer side.
interface fb_line_writer_if #(
    parameter int ADDR_W = 17
);
    logic              capture_en;
    logic              frame_start;
    logic              frame_end;
    logic              line_start;
    logic              pix_valid;
    logic [15:0]       pix_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              frame_done;
    logic              busy;
    logic [3:0]        err_flags;

    modport slave (
        input  capture_en, frame_start, frame_end, line_start, pix_valid, pix_data,
        output wr_en, wr_addr, wr_data, frame_done, busy, err_flags
    );

    modport master (
        output capture_en, frame_start, frame_end, line_start, pix_valid, pix_data,
        input  wr_en, wr_addr, wr_data, frame_done, busy, err_flags
    );
endinterface

// File: rtl/fb_word_packer.sv
// Packs 16-bit two-pixel beats into 32-bit words; earlier beat lands in [15:0].
// clr drops any half-packed word; a beat arriving with clr starts a fresh word.
module fb_word_packer (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        beat_valid,
    input  logic [15:0] beat_data,
    output logic        half_full,
    output logic [31:0] word_data,
    output logic        word_valid
);
    logic        phase_q, phase_d;
    logic [15:0] low_q, low_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;

    always_comb begin
        phase_d = clr ? 1'b0 : phase_q;
        low_d   = low_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (beat_valid) begin
            if (!phase_d) begin
                low_d   = beat_data;
                phase_d = 1'b1;
            end else begin
                word_d  = {beat_data, low_q};
                valid_d = 1'b1;
                phase_d = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            phase_q <= 1'b0;
            low_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            low_q   <= low_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign half_full  = phase_q;
    assign word_data  = word_q;
    assign word_valid = valid_q;
endmodule

// File: rtl/fb_line_writer.sv
// Packs RAW8 beats into 32-bit frame-buffer words, addresses them from frame and
// line markers (line_base + word offset, no multiplier) and flags bad geometry.
module fb_line_writer
    import fb_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 17
) (
    input  logic            sys_clk,
    input  logic            reset,
    fb_line_writer_if.slave bus
);
    localparam int LIDX_W = $clog2(HEIGHT + 2);
    localparam int PIX_W  = $clog2(WIDTH + 1);

    localparam logic [LIDX_W-1:0] LAST_LINE = LIDX_W'(HEIGHT);
    localparam logic [LIDX_W-1:0] OVER_LINE = LIDX_W'(HEIGHT + 1);
    localparam logic [PIX_W-1:0]  LINE_PIX  = PIX_W'(WIDTH);
    localparam logic [ADDR_W-1:0] WPL       = ADDR_W'(words_per_line(WIDTH));

    fb_state_e         state_q, state_d;
    logic [LIDX_W-1:0] line_idx_q, line_idx_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [ADDR_W-1:0] word_ptr_q, word_ptr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic              no_line_q, no_line_d;
    logic [3:0]        err_q, err_d;
    logic              frame_done_q, frame_done_d;

    logic              accept_fs;
    logic              pk_clr;
    logic              pk_valid;
    logic              pk_half;
    logic [31:0]       pk_word;
    logic              pk_word_valid;

    // An active frame is restarted regardless of capture_en; only arming needs it.
    assign accept_fs = bus.frame_start && (state_q == ST_ACTIVE || bus.capture_en);

    always_comb begin
        state_d      = state_q;
        line_idx_d   = line_idx_q;
        line_base_d  = line_base_q;
        word_ptr_d   = word_ptr_q;
        wr_addr_d    = wr_addr_q;
        pix_cnt_d    = pix_cnt_q;
        no_line_d    = no_line_q;
        err_d        = err_q;
        frame_done_d = 1'b0;
        pk_clr       = 1'b0;
        pk_valid     = 1'b0;

        if (accept_fs) begin
            err_d       = '0;
            err_d[ERR_SYNC] = (state_q == ST_ACTIVE);
            line_idx_d  = '0;
            line_base_d = '0;
            word_ptr_d  = '0;
            pix_cnt_d   = '0;
            no_line_d   = 1'b1;
            pk_clr      = 1'b1;
            state_d     = bus.capture_en ? ST_ACTIVE : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_ACTIVE: begin
                    if (bus.line_start) begin
                        pk_clr = 1'b1;
                        if (pk_half) begin
                            err_d[ERR_LINE_LEN] = 1'b1;
                        end
                        if (!no_line_q && line_idx_q <= LAST_LINE && pix_cnt_q < LINE_PIX) begin
                            err_d[ERR_LINE_LEN] = 1'b1;
                        end
                        if (!no_line_q) begin
                            line_base_d = line_base_q + WPL;
                        end
                        word_ptr_d = line_base_d;
                        pix_cnt_d  = '0;
                        no_line_d  = 1'b0;
                        if (line_idx_q != OVER_LINE) begin
                            line_idx_d = line_idx_q + LIDX_W'(1);
                        end
                    end

                    // Uses the post-line_start view so a coincident beat opens the new line.
                    if (bus.pix_valid && !no_line_d) begin
                        if (line_idx_d == OVER_LINE) begin
                            err_d[ERR_LONG_FRAME] = 1'b1;
                        end else if (pix_cnt_d >= LINE_PIX) begin
                            err_d[ERR_LINE_LEN] = 1'b1;
                        end else begin
                            pk_valid  = 1'b1;
                            pix_cnt_d = pix_cnt_d + PIX_W'(2);
                            if (pk_half && !pk_clr) begin
                                wr_addr_d  = word_ptr_d;
                                word_ptr_d = word_ptr_d + ADDR_W'(1);
                            end
                        end
                    end

                    if (bus.frame_end) begin
                        if (line_idx_d != LAST_LINE) begin
                            err_d[ERR_SHORT_FRAME] = 1'b1;
                        end
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            line_idx_q   <= '0;
            line_base_q  <= '0;
            word_ptr_q   <= '0;
            wr_addr_q    <= '0;
            pix_cnt_q    <= '0;
            no_line_q    <= 1'b1;
            err_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_idx_q   <= line_idx_d;
            line_base_q  <= line_base_d;
            word_ptr_q   <= word_ptr_d;
            wr_addr_q    <= wr_addr_d;
            pix_cnt_q    <= pix_cnt_d;
            no_line_q    <= no_line_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
        end
    end

    fb_word_packer u_packer (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .clr        (pk_clr),
        .beat_valid (pk_valid),
        .beat_data  (bus.pix_data),
        .half_full  (pk_half),
        .word_data  (pk_word),
        .word_valid (pk_word_valid)
    );

    assign bus.wr_en      = pk_word_valid;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = pk_word;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = (state_q == ST_ACTIVE);
    assign bus.err_flags  = err_q;
endmodule

// File: doc/fb_line_writer.md
# fb_line_writer

Sits between the MIPI receiver's pixel output and the dual-clock frame buffer RAM. It packs 8-bit RAW pixels, arriving two per beat from the two-lane receiver, into 32-bit words. It generates the RAM word address from frame and line markers, which replaces the ad-hoc `cX+cY` addressing. It checks frame geometry and reports errors, so the HDMI and serial readout always see a pixel-aligned buffer.

## Interface
Parameters:
- `WIDTH`, 640, active pixels per line; must be a multiple of 4.
- `HEIGHT`, 480, active lines per frame.
- `ADDR_W`, 17, RAM word-address width; must hold `WIDTH*HEIGHT/4-1`.

Ports:
- `sys_clk`  in  1  single clock for all logic; 100 MHz in the system.
- `reset`  in  1  asynchronous, active-low reset.
- `capture_en`  in  1  arms capture; sampled only when `frame_start` is accepted.
- `frame_start`  in  1  one-cycle pulse, CSI frame-start short packet.
- `frame_end`  in  1  one-cycle pulse, CSI frame-end short packet.
- `line_start`  in  1  one-cycle pulse, start of a RAW8 long-packet payload.
- `pix_valid`  in  1  `pix_data` is valid this cycle.
- `pix_data`  in  16  two pixels; `[7:0]` is the earlier pixel.
- `wr_en`  out  1  RAM write strobe.
- `wr_addr`  out  ADDR_W  RAM word address.
- `wr_data`  out  32  four pixels; `[7:0]` is the leftmost.
- `frame_done`  out  1  one-cycle pulse after a frame ends.
- `busy`  out  1  high while state is ACTIVE.
- `err_flags`  out  4  sticky bits: {sync, short_frame, long_frame, line_len}. Cleared on accepted `frame_start`.

## Operation
- States: IDLE, ACTIVE.
- IDLE → ACTIVE on `frame_start` while `capture_en`=1. This clears `err_flags`, `line_idx`, `line_base` and `word_ptr`, and sets the "no line yet" flag.
- ACTIVE → IDLE on `frame_end`. `frame_done` pulses on the next cycle. If `line_idx` ≠ `HEIGHT`, set `short_frame`.
- `frame_start` in ACTIVE restarts the frame as above. It sets `sync` after the clear, and re-samples `capture_en`.
- `line_start` in ACTIVE:
  - If not the first line, `line_base += WIDTH/4`.
  - `word_ptr` ← `line_base` (new value); the beat counter and pixel-in-line counter are cleared.
  - `line_idx` increments, saturating at `HEIGHT+1`.
  - A line start arriving with half a word packed discards the half and sets `line_len`.
- Beats accepted only in ACTIVE, after the first `line_start`, with `line_idx` ≤ `HEIGHT`.
  - Beats before the first `line_start` are dropped silently.
  - Beats on line `HEIGHT+1` are dropped and set `long_frame`.
- Packing:
  - Even beat fills `word[15:0]`.
  - Odd beat fills `word[31:16]` and issues a write at `word_ptr`, then `word_ptr += 1`.
  - Beats after `WIDTH` pixels in a line are dropped and set `line_len`.
  - A `line_start` after fewer than `WIDTH` pixels sets `line_len`.
- No multiplier: address is `line_base + word offset`. The counters are the only arithmetic.
- Simultaneous events:
  - `frame_start` with a beat: the beat is dropped.
  - `line_start` with a beat: the beat is the first of the new line.
  - `frame_end` with a beat: the beat is processed first.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `frame_done`=0, `busy`=0, `err_flags`=0, state IDLE.
- Write latency: `wr_en`, `wr_addr` and `wr_data` are registered one cycle after the odd beat. `wr_en` is a single-cycle strobe.
- Throughput: one beat per cycle sustained, giving at most one write every 2 cycles.
- `frame_done` is high exactly 1 cycle, the cycle after `frame_end`.
- Reset asserted mid-frame: all state returns to IDLE immediately. A half-packed word is lost and no write is issued.

## Structure
- Package `fb_pkg`:
  - State enum.
  - `WORDS_PER_LINE = WIDTH/4` and `FB_WORDS = WIDTH*HEIGHT/4`.
  - `err_flags` bit indices.
- Sub-module `fb_word_packer`: takes a 16-bit beat stream with a clear input. It outputs a 32-bit word and a one-cycle `word_valid`. The top level owns the counters, address and FSM.

## Test plan
- Full frame, `WIDTH`=8, `HEIGHT`=2: beats 0x0100, 0x0302, … → 4 writes:
  - addr 0 = 0x03020100, addr 1 = 0x07060504.
  - addr 2 and addr 3 as expected.
  - `frame_done` 1 cycle after `frame_end`; `err_flags`=0.
- Line with 10 pixels (`WIDTH`=8) → only 2 writes on that line; `line_len` set; next line starts at addr 2.
- `frame_end` after 1 of 2 lines → `short_frame`=1, `frame_done` pulses, state IDLE.
- `frame_start` with `capture_en`=0 → no writes and `busy`=0 for the whole frame.
- `frame_start` mid-line → `sync`=1, next `line_start` writes addr 0, no write from the partial word.
- Reset low during an odd beat → no `wr_en`; all outputs 0 within the same cycle.
